// File: rtl/multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Control FSM for a multi-cycle RV32I-style datapath. Each instruction runs
// FETCH -> DECODE -> execute state(s) -> FETCH. Loads and stores hold a
// data-bus request until the bus reports completion. Every output is decoded
// from the current state; only aluControl also uses instrCode, and only the
// S_MEM/L_MEM outputs also use busReady.
//
// Build option:
//   ILLEGAL_TRAP_EN  defined   : an unknown opcode parks the FSM in TRAP
//                                with the sticky illegalInstr flag set,
//                                until reset.
//                    undefined : an unknown opcode behaves as a NOP that
//                                advances the PC. The illegalInstr port is
//                                not present.
//
// Ports:
//   clk            in   system clock, rising-edge active
//   reset_n        in   asynchronous active-low reset
//   instrCode[31:0] in  instruction held in the datapath IR
//   busReady       in   data-bus transfer completes this cycle
//   irEn           out  load the IR from instruction memory
//   PCEn           out  update the PC
//   regFileWe      out  register-file write enable
//   aluControl[3:0] out ALU operation code
//   aluSrcMuxSel   out  0 = rs2, 1 = immExt
//   RFWDSrcMuxSel[1:0] out writeback: 0 = ALU, 1 = load, 2 = PC+imm, 3 = PC+4
//   RD1MuxSel      out  1 forces ALU operand a to zero
//   branch         out  conditional-branch qualifier
//   Jump           out  JAL target select
//   busReq         out  data-bus request
//   busWe          out  data-bus write
//   illegalInstr   out  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
//
// State   | meaning
// --------+--------------------------------------------------------------
// FETCH   | load the IR
// DECODE  | select the execute state from the opcode
// R_EXE   | register-register ALU op, write rd
// I_EXE   | register-immediate ALU op, write rd
// B_EXE   | branch compare, PC update qualified by branch
// LU_EXE  | LUI: 0 + imm to rd
// AU_EXE  | AUIPC: PC + imm to rd
// J_EXE   | JAL: PC + 4 to rd, jump
// JL_EXE  | JALR: PC + 4 to rd, target from rs1 + imm
// S_EXE   | store address generation
// S_MEM   | store bus transfer, wait for busReady
// L_EXE   | load address generation
// L_MEM   | load bus transfer, wait for busReady, then write rd
// TRAP    | unknown opcode
// ---------------------------------------------------------------------------
module multi_cycle_control_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        irEn,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [1:0]  RFWDSrcMuxSel,
  output logic        RD1MuxSel,
  output logic        branch,
  output logic        Jump,
  output logic        busReq,
  output logic        busWe
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegalInstr
`endif
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_L  = 7'b0000011;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_LOAD = 2'd1;
  localparam logic [1:0] WD_PCIMM = 2'd2;
  localparam logic [1:0] WD_PC4  = 2'd3;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_R_EXE,
    ST_I_EXE,
    ST_B_EXE,
    ST_LU_EXE,
    ST_AU_EXE,
    ST_J_EXE,
    ST_JL_EXE,
    ST_S_EXE,
    ST_S_MEM,
    ST_L_EXE,
    ST_L_MEM,
    ST_TRAP
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_bit30;
  logic       w_unused;

  assign w_opcode = instrCode[6:0];
  assign w_funct3 = instrCode[14:12];
  assign w_bit30  = instrCode[30];

  // Operand fields are consumed by the datapath, not by this controller.
  assign w_unused = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        case (w_opcode)
          OP_R:    w_next = ST_R_EXE;
          OP_I:    w_next = ST_I_EXE;
          OP_B:    w_next = ST_B_EXE;
          OP_LU:   w_next = ST_LU_EXE;
          OP_AU:   w_next = ST_AU_EXE;
          OP_J:    w_next = ST_J_EXE;
          OP_JL:   w_next = ST_JL_EXE;
          OP_S:    w_next = ST_S_EXE;
          OP_L:    w_next = ST_L_EXE;
          default: w_next = ST_TRAP;
        endcase
      end
      ST_R_EXE,
      ST_I_EXE,
      ST_B_EXE,
      ST_LU_EXE,
      ST_AU_EXE,
      ST_J_EXE,
      ST_JL_EXE: w_next = ST_FETCH;
      ST_S_EXE:  w_next = ST_S_MEM;
      ST_S_MEM:  w_next = busReady ? ST_FETCH : ST_S_MEM;
      ST_L_EXE:  w_next = ST_L_MEM;
      ST_L_MEM:  w_next = busReady ? ST_FETCH : ST_L_MEM;
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP:   w_next = ST_TRAP;
`else
      ST_TRAP:   w_next = ST_FETCH;
`endif
      default:   w_next = ST_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    irEn          = 1'b0;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = WD_ALU;
    RD1MuxSel     = 1'b0;
    branch        = 1'b0;
    Jump          = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    case (r_state)
      ST_FETCH: irEn = 1'b1;
      ST_R_EXE: begin
        PCEn       = 1'b1;
        regFileWe  = 1'b1;
        aluControl = {w_bit30, w_funct3};
      end
      ST_I_EXE: begin
        PCEn         = 1'b1;
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // bit 30 only distinguishes SRAI from SRLI; elsewhere it is immediate data
        aluControl   = (w_funct3 == 3'b101) ? {w_bit30, w_funct3} : {1'b0, w_funct3};
      end
      ST_B_EXE: begin
        PCEn       = 1'b1;
        branch     = 1'b1;
        aluControl = {1'b0, w_funct3};
      end
      ST_LU_EXE: begin
        PCEn         = 1'b1;
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        RD1MuxSel    = 1'b1;
        RFWDSrcMuxSel = WD_ALU;
      end
      ST_AU_EXE: begin
        PCEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = WD_PCIMM;
      end
      ST_J_EXE: begin
        PCEn          = 1'b1;
        regFileWe     = 1'b1;
        Jump          = 1'b1;
        RFWDSrcMuxSel = WD_PC4;
      end
      ST_JL_EXE: begin
        PCEn          = 1'b1;
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = WD_PC4;
      end
      ST_S_EXE: aluSrcMuxSel = 1'b1;
      ST_S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busReq       = 1'b1;
        busWe        = 1'b1;
        PCEn         = busReady;
      end
      ST_L_EXE: aluSrcMuxSel = 1'b1;
      ST_L_MEM: begin
        aluSrcMuxSel = 1'b1;
        busReq       = 1'b1;
        // commit only in the completion cycle so a wait-state load never
        // writes stale bus data
        regFileWe    = busReady;
        PCEn         = busReady;
        RFWDSrcMuxSel = busReady ? WD_LOAD : WD_ALU;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: PCEn = 1'b0;
`else
      ST_TRAP: PCEn = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  // Set on the edge that enters TRAP so the flag is visible in the first TRAP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal <= 1'b0;
    end else if (w_next == ST_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegalInstr = r_illegal;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instrCode;
  logic        busReady;
  logic        irEn, PCEn, regFileWe, aluSrcMuxSel, RD1MuxSel, branch, Jump, busReq, busWe;
  logic [3:0]  aluControl;
  logic [1:0]  RFWDSrcMuxSel;
  logic        w_ill;

  always #5 clk = ~clk;

  multi_cycle_control_unit dut (
    .clk(clk), .reset_n(reset_n), .instrCode(instrCode), .busReady(busReady),
    .irEn(irEn), .PCEn(PCEn), .regFileWe(regFileWe), .aluControl(aluControl),
    .aluSrcMuxSel(aluSrcMuxSel), .RFWDSrcMuxSel(RFWDSrcMuxSel), .RD1MuxSel(RD1MuxSel),
    .branch(branch), .Jump(Jump), .busReq(busReq), .busWe(busWe)
`ifdef ILLEGAL_TRAP_EN
    , .illegalInstr(w_ill)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign w_ill = 1'b0;
`endif

  // {ill, irEn, PCEn, we, alu[3:0], src, wd[1:0], rd1, br, jump, busReq, busWe}
  logic [15:0] w_act;
  assign w_act = {w_ill, irEn, PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
                  RD1MuxSel, branch, Jump, busReq, busWe};

  typedef struct {
    logic [15:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [15:0] mk(input bit ir, input bit pc, input bit we,
                                     input logic [3:0] alu, input bit src, input logic [1:0] wd,
                                     input bit rd1, input bit br, input bit j,
                                     input bit bq, input bit bw, input bit ill);
    return {ill, ir, pc, we, alu, src, wd, rd1, br, j, bq, bw};
  endfunction

  localparam logic [15:0] V_FETCH = 16'h4000;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents one control word; compare against the queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check(e.tag, w_act, e.v);
      end
    end
  end

  // One clock cycle of stimulus plus its expected control word.
  task automatic cyc(input logic [31:0] instr, input logic rdy, input logic [15:0] e,
                     input string tag);
    exp_t x;
    @(negedge clk);
    instrCode = instr;
    busReady  = rdy;
    x.v   = e;
    x.tag = tag;
    q.push_back(x);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: the control words an instruction produces, cycle by cycle.
  task automatic run_instr(input logic [31:0] instr, input int waits);
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30;
    op  = instr[6:0];
    f3  = instr[14:12];
    b30 = instr[30];
    cyc(instr, rnd(), V_FETCH, "fetch");
    cyc(instr, rnd(), 16'h0000, "decode");
    case (op)
      7'b0110011: cyc(instr, rnd(), mk(0,1,1,{b30,f3},0,2'd0,0,0,0,0,0,0), "r_exe");
      7'b0010011: cyc(instr, rnd(),
                      mk(0,1,1,(f3 == 3'b101) ? {b30,f3} : {1'b0,f3},1,2'd0,0,0,0,0,0,0), "i_exe");
      7'b1100011: cyc(instr, rnd(), mk(0,1,0,{1'b0,f3},0,2'd0,0,1,0,0,0,0), "b_exe");
      7'b0110111: cyc(instr, rnd(), mk(0,1,1,4'd0,1,2'd0,1,0,0,0,0,0), "lu_exe");
      7'b0010111: cyc(instr, rnd(), mk(0,1,1,4'd0,0,2'd2,0,0,0,0,0,0), "au_exe");
      7'b1101111: cyc(instr, rnd(), mk(0,1,1,4'd0,0,2'd3,0,0,1,0,0,0), "j_exe");
      7'b1100111: cyc(instr, rnd(), mk(0,1,1,4'd0,1,2'd3,0,0,0,0,0,0), "jl_exe");
      7'b0100011: begin
        cyc(instr, rnd(), mk(0,0,0,4'd0,1,2'd0,0,0,0,0,0,0), "s_exe");
        for (int k = 0; k <= waits; k++) begin
          bit last;
          last = (k == waits);
          cyc(instr, last, mk(0,last,0,4'd0,1,2'd0,0,0,0,1,1,0), "s_mem");
        end
      end
      7'b0000011: begin
        cyc(instr, rnd(), mk(0,0,0,4'd0,1,2'd0,0,0,0,0,0,0), "l_exe");
        for (int k = 0; k <= waits; k++) begin
          bit last;
          last = (k == waits);
          cyc(instr, last, mk(0,last,last,4'd0,1,last ? 2'd1 : 2'd0,0,0,0,1,0,0), "l_mem");
        end
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++)
          cyc(instr, rnd(), mk(0,0,0,4'd0,0,2'd0,0,0,0,0,0,1), "trap");
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("trap_reset", w_act, V_FETCH);
        @(posedge clk);
        #2 reset_n = 1'b1;
`else
        cyc(instr, rnd(), mk(0,1,0,4'd0,0,2'd0,0,0,0,0,0,0), "trap_nop");
`endif
      end
    endcase
  endtask

  // Load aborted by reset while waiting on the bus.
  task automatic reset_mid_load();
    logic [31:0] lw;
    lw = 32'h0080A283;
    cyc(lw, 1'b1, V_FETCH, "rml_fetch");
    cyc(lw, 1'b1, 16'h0000, "rml_decode");
    cyc(lw, 1'b1, mk(0,0,0,4'd0,1,2'd0,0,0,0,0,0,0), "rml_l_exe");
    cyc(lw, 1'b0, mk(0,0,0,4'd0,1,2'd0,0,0,0,1,0,0), "rml_l_mem");
    @(negedge clk);
    busReady = 1'b0;
    #1 check("rml_pre_reset", w_act, mk(0,0,0,4'd0,1,2'd0,0,0,0,1,0,0));
    reset_n = 1'b0;
    #1 check("rml_in_reset", w_act, V_FETCH);
    @(posedge clk);
    #1 check("rml_held", w_act, V_FETCH);
    #1 reset_n = 1'b1;
  endtask

  logic [6:0] legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1100111, 7'b0100011, 7'b0000011};
  logic [6:0] bad_ops[4]   = '{7'h00, 7'h7F, 7'h0F, 7'h73};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    instrCode = 32'h0;
    busReady  = 1'b1;
    #2 check("reset_state", w_act, V_FETCH);
    #5 reset_n = 1'b1;

    run_instr(32'h002081B3, 0);   // add
    run_instr(32'h402081B3, 0);   // sub
    run_instr(32'h4030D093, 0);   // srai
    run_instr(32'h4020F093, 0);   // andi with bit 30 set in the immediate
    run_instr(32'h0080A283, 2);   // lw with two wait states
    run_instr(32'h0050A423, 0);   // sw, bus ready immediately
    run_instr(32'h0050A423, 3);
    reset_mid_load();
    run_instr(32'h002081B3, 0);   // starts from FETCH after the aborted load

    for (int n = 0; n < 200; n++) begin
      logic [31:0] ins;
      ins = $urandom;
`ifdef ILLEGAL_TRAP_EN
      ins[6:0] = legal_ops[$urandom_range(0, 8)];
`else
      if ($urandom_range(0, 9) == 0) ins[6:0] = bad_ops[$urandom_range(0, 3)];
      else                           ins[6:0] = legal_ops[$urandom_range(0, 8)];
`endif
      run_instr(ins, $urandom_range(0, 3));
    end

    run_instr(32'h00000000, 0);   // illegal opcode
    run_instr(32'h002081B3, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
